// File: rtl/seg_capture_if.sv
// seg_capture_if: display bus tap and readback results.
// master drives i_an/i_seg; slave drives the o_* results.
//   i_an  [N_DIG-1:0]  anode select, active-low
//   i_seg [6:0]        {g,f,e,d,c,b,a}, active-low
//   o_digits, o_valid, o_upd, o_upd_idx, o_err
//   o_err_cnt only with SEG_CAPTURE_ERR_CNT_EN
interface seg_capture_if #(
  parameter int N_DIG = 4
) ();
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [N_DIG-1:0]   i_an;
  logic [6:0]         i_seg;
  logic [4*N_DIG-1:0] o_digits;
  logic [N_DIG-1:0]   o_valid;
  logic               o_upd;
  logic [IW-1:0]      o_upd_idx;
  logic               o_err;
`ifdef SEG_CAPTURE_ERR_CNT_EN
  logic [7:0]         o_err_cnt;
`endif

  modport master (
    output i_an, i_seg,
    input  o_digits, o_valid, o_upd,
    input  o_upd_idx, o_err
`ifdef SEG_CAPTURE_ERR_CNT_EN
    , input o_err_cnt
`endif
  );

  modport slave (
    input  i_an, i_seg,
    output o_digits, o_valid, o_upd,
    output o_upd_idx, o_err
`ifdef SEG_CAPTURE_ERR_CNT_EN
    , output o_err_cnt
`endif
  );
endinterface

// File: rtl/seg_capture.sv
// seg_capture: seven-segment readback decoder.
// Ports: i_clk, i_rst_n (sync, active-low), bus (seg_capture_if.slave).
// A scan slot is captured once its anode/segment pair is stable
// for SETTLE edges; the pattern is decoded back to a hex nibble.
// Macro SEG_CAPTURE_ERR_CNT_EN adds a saturating o_err_cnt.
module seg_capture #(
  parameter int N_DIG  = 4,
  parameter int SETTLE = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  seg_capture_if.slave bus
);
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    HELD
  } state_t;

  state_t             state;
  logic [N_DIG-1:0]   r_an;
  logic [6:0]         r_seg;
  logic [CW-1:0]      cnt;
  logic [4*N_DIG-1:0] digits;
  logic [N_DIG-1:0]   valid;
  logic               upd;
  logic [IW-1:0]      upd_idx;
  logic               err;

  logic [N_DIG-1:0]   an_act;
  logic               one_low;
  logic               changed;
  logic [IW-1:0]      idx;
  logic               dec_ok;
  logic               blank;
  logic [3:0]         nib;

  assign an_act  = ~bus.i_an;
  assign one_low = (an_act != '0) &&
                   ((an_act & (an_act - 1'b1)) == '0);
  assign changed = {bus.i_an, bus.i_seg} != {r_an, r_seg};
  assign blank   = (r_seg == 7'h7f);

  always_comb begin
    idx = '0;
    for (int k = 0; k < N_DIG; k++)
      if (!r_an[k]) idx = IW'(k);
  end

  always_comb begin
    dec_ok = 1'b1;
    nib    = 4'h0;
    case (r_seg)
      7'b100_0000: nib = 4'h0;
      7'b111_1001: nib = 4'h1;
      7'b010_0100: nib = 4'h2;
      7'b011_0000: nib = 4'h3;
      7'b001_1001: nib = 4'h4;
      7'b001_0010: nib = 4'h5;
      7'b000_0010: nib = 4'h6;
      7'b111_1000: nib = 4'h7;
      7'b000_0000: nib = 4'h8;
      7'b001_0000: nib = 4'h9;
      7'b000_1000: nib = 4'ha;
      7'b000_0011: nib = 4'hb;
      7'b100_0110: nib = 4'hc;
      7'b010_0001: nib = 4'hd;
      7'b000_0110: nib = 4'he;
      7'b000_1110: nib = 4'hf;
      default:     dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      r_an    <= '1;
      r_seg   <= '1;
      cnt     <= '0;
      digits  <= '0;
      valid   <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
      err     <= 1'b0;
    end else begin
      upd <= 1'b0;
      err <= 1'b0;
      if (changed) begin
        r_an  <= bus.i_an;
        r_seg <= bus.i_seg;
        cnt   <= CW'(1);
        state <= one_low ? SETTLING : IDLE;
      end else if (state == SETTLING) begin
        if (cnt == CW'(SETTLE - 1)) begin
          // r already equals the inputs, so capture from r
          state   <= HELD;
          upd     <= 1'b1;
          upd_idx <= idx;
          valid[idx] <= dec_ok;
          err     <= !dec_ok && !blank;
          if (dec_ok)
            digits[{idx, 2'b00} +: 4] <= nib;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef SEG_CAPTURE_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      err_cnt <= '0;
    else if (err && err_cnt != 8'hff)
      err_cnt <= err_cnt + 1'b1;
  end

  assign bus.o_err_cnt = err_cnt;
`endif

  assign bus.o_digits  = digits;
  assign bus.o_valid   = valid;
  assign bus.o_upd     = upd;
  assign bus.o_upd_idx = upd_idx;
  assign bus.o_err     = err;
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed checks of seg_capture.
// N_DIG=4, SETTLE=4; err counter checks when the macro is set.
module tb_seg_capture;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   n_upd;
  int   n_err;
  logic [1:0] idx_log[$];

  seg_capture_if #(.N_DIG(4)) bus ();

  seg_capture #(
    .N_DIG (4),
    .SETTLE(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.o_upd === 1'b1) begin
      n_upd++;
      idx_log.push_back(bus.o_upd_idx);
    end
    if (bus.o_err === 1'b1) n_err++;
  endtask

  task automatic hold(input logic [3:0] an,
                      input logic [6:0] seg,
                      input int n);
    bus.i_an  = an;
    bus.i_seg = seg;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    n_upd = 0;
    n_err = 0;
    idx_log.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr();
    rst_n = 1'b0;
    bus.i_an  = 4'hf;
    bus.i_seg = 7'h7f;
    step();
    step();
    chk("rst_digits", 32'(bus.o_digits), 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_upd", 32'(bus.o_upd), 32'h0);
    chk("rst_idx", 32'(bus.o_upd_idx), 32'h0);
    chk("rst_err", 32'(bus.o_err), 32'h0);
`ifdef SEG_CAPTURE_ERR_CNT_EN
    chk("rst_errcnt", 32'(bus.o_err_cnt), 32'h0);
`endif
    rst_n = 1'b1;

    clr();
    hold(4'b1110, 7'b010_0100, 3);
    chk("d2_early", 32'(n_upd), 32'd0);
    hold(4'b1110, 7'b010_0100, 1);
    chk("d2_upd", 32'(bus.o_upd), 32'h1);
    chk("d2_nib", 32'(bus.o_digits[3:0]), 32'h2);
    chk("d2_valid", 32'(bus.o_valid), 32'h1);
    chk("d2_idx", 32'(bus.o_upd_idx), 32'h0);
    chk("d2_err", 32'(bus.o_err), 32'h0);
    hold(4'b1110, 7'b010_0100, 6);
    chk("d2_once", 32'(n_upd), 32'd1);

    clr();
    hold(4'b0111, 7'b111_1000, 6);
    hold(4'b1011, 7'b100_0000, 6);
    hold(4'b1101, 7'b000_1000, 6);
    hold(4'b1110, 7'b010_0001, 6);
    chk("scan_digits", 32'(bus.o_digits), 32'h70ad);
    chk("scan_valid", 32'(bus.o_valid), 32'hf);
    chk("scan_npulse", 32'(n_upd), 32'd4);
    chk("scan_nerr", 32'(n_err), 32'd0);
    if (idx_log.size() == 4) begin
      chk("scan_i0", 32'(idx_log[0]), 32'd3);
      chk("scan_i1", 32'(idx_log[1]), 32'd2);
      chk("scan_i2", 32'(idx_log[2]), 32'd1);
      chk("scan_i3", 32'(idx_log[3]), 32'd0);
    end

    clr();
    hold(4'b1011, 7'b111_1111, 6);
    chk("blank_upd", 32'(n_upd), 32'd1);
    chk("blank_err", 32'(n_err), 32'd0);
    chk("blank_valid", 32'(bus.o_valid), 32'hb);
    chk("blank_dig", 32'(bus.o_digits), 32'h70ad);

    clr();
    hold(4'b0111, 7'b101_0101, 6);
    chk("bad_upd", 32'(n_upd), 32'd1);
    chk("bad_err", 32'(n_err), 32'd1);
    chk("bad_valid", 32'(bus.o_valid), 32'h3);
    chk("bad_dig", 32'(bus.o_digits), 32'h70ad);
`ifdef SEG_CAPTURE_ERR_CNT_EN
    chk("errcnt_1", 32'(bus.o_err_cnt), 32'd1);
    for (int i = 0; i < 300; i++)
      hold(4'b0111, (i % 2 == 0) ? 7'b101_0100
                                 : 7'b101_0101, 4);
    step();
    chk("errcnt_sat", 32'(bus.o_err_cnt), 32'd255);
`endif

    clr();
    hold(4'b1110, 7'b011_0000, 3);
    hold(4'b1110, 7'b001_0010, 4);
    chk("glitch_upd", 32'(n_upd), 32'd1);
    chk("glitch_nib", 32'(bus.o_digits[3:0]), 32'h5);
    clr();
    hold(4'b1100, 7'b000_0000, 8);
    chk("multi_upd", 32'(n_upd), 32'd0);
    chk("multi_err", 32'(n_err), 32'd0);

    clr();
    hold(4'b1101, 7'b111_1001, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_digits", 32'(bus.o_digits), 32'h0);
    chk("mrst_valid", 32'(bus.o_valid), 32'h0);
    clr();
    hold(4'b1101, 7'b111_1001, 3);
    chk("mrst_early", 32'(n_upd), 32'd0);
    hold(4'b1101, 7'b111_1001, 1);
    chk("mrst_upd", 32'(bus.o_upd), 32'h1);
    chk("mrst_idx", 32'(bus.o_upd_idx), 32'h1);
    chk("mrst_dig", 32'(bus.o_digits), 32'h0010);
    chk("mrst_valid2", 32'(bus.o_valid), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
